// File: rtl/param_queue_controller.sv
// Parametrised first-word-fall-through FIFO queue controller with watermarks and flush.
// Optional sticky overflow/underflow flags are built when QUEUE_ERR_FLAGS_EN is defined.
module param_queue_controller #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     enq,
  input  logic                     deq,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
`ifdef QUEUE_ERR_FLAGS_EN
  input  logic                     err_clr,
  output logic                     overflow,
  output logic                     underflow,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0] AF_CNT   = AF_LEVEL[AW:0];
  localparam logic [AW:0] AE_CNT   = AE_LEVEL[AW:0];

  if ((1 << AW) != DEPTH || DEPTH < 2) begin : g_bad_depth
    $fatal(1, "param_queue_controller: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $fatal(1, "param_queue_controller: AF_LEVEL must not exceed DEPTH");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      head;
  logic [AW:0]      tail;
  logic             deq_acc;
  logic             enq_acc;

  // A full queue can still take a word when the head leaves in the same cycle.
  assign deq_acc = deq && !empty;
  assign enq_acc = enq && (!full || deq_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_acc) tail <= tail + 1'b1;
      if (deq_acc) head <= head + 1'b1;
      case ({enq_acc, deq_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data-only: never reset, and left untouched by flush.
  always_ff @(posedge clk) begin
    if (enq_acc && !flush) mem[tail[AW-1:0]] <= data_in;
  end

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);
  assign data_out     = empty ? '0 : mem[head[AW-1:0]];

`ifdef QUEUE_ERR_FLAGS_EN
  // Setting wins over err_clr so an error in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (enq && !enq_acc) overflow <= 1'b1;
      else if (err_clr)    overflow <= 1'b0;
      if (deq && empty)    underflow <= 1'b1;
      else if (err_clr)    underflow <= 1'b0;
    end
  end
`endif

endmodule
